// File: rtl/booth_sdiv.sv
// booth_sdiv: sequential signed restoring divider, one quotient bit per clock, valid/ready on both sides.
// Optional BOOTH_SDIV_EARLY_EXIT_EN skips iteration for a zero divisor or |dividend| < |divisor|.
module booth_sdiv #(
  parameter int unsigned DW_N = 16,
  parameter int unsigned DW_D = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW_N-1:0] dividend,
  input  logic [DW_D-1:0] divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW_N-1:0] quotient,
  output logic [DW_D-1:0] remainder,
  output logic            div_zero,
  output logic            ovf
);
  localparam int unsigned CntW = $clog2(DW_N);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e          r_state;
  logic            r_sign_q, r_sign_r, r_dz, r_ovf_c;
  logic [DW_N-1:0] r_nmag;
  logic [DW_D:0]   r_dmag, r_prem;
  logic [CntW-1:0] r_cnt;
  logic            r_in_ready, r_out_valid, r_div_zero, r_ovf;
  logic [DW_N-1:0] r_quot;
  logic [DW_D-1:0] r_rem;
`ifdef BOOTH_SDIV_EARLY_EXIT_EN
  logic            r_early;
  logic            w_skip;
`endif

  logic            w_accept;
  logic [DW_N-1:0] w_nmag;
  logic [DW_D:0]   w_dext, w_dmag, w_sub;
  logic [DW_D+1:0] w_shift;
  logic            w_ge, w_ovf_c;
  logic [DW_D-1:0] w_rmag;

  assign w_accept = in_valid & r_in_ready;
  assign w_nmag   = dividend[DW_N-1] ? -dividend : dividend;
  assign w_dext   = {divisor[DW_D-1], divisor};
  assign w_dmag   = w_dext[DW_D] ? -w_dext : w_dext;
  assign w_ovf_c  = (dividend == {1'b1, {(DW_N-1){1'b0}}}) & (&divisor);

  // The partial remainder stays below |divisor|, so the shifted value never loses its top bit.
  assign w_shift = {r_prem, r_nmag[DW_N-1]};
  assign w_ge    = w_shift >= {1'b0, r_dmag};
  assign w_sub   = w_shift[DW_D:0] - r_dmag;
  assign w_rmag  = r_prem[DW_D-1:0];

`ifdef BOOTH_SDIV_EARLY_EXIT_EN
  assign w_skip = ~|divisor | ((DW_N+1)'(w_nmag) < (DW_N+1)'(w_dmag));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_dz        <= 1'b0;
      r_ovf_c     <= 1'b0;
      r_nmag      <= '0;
      r_dmag      <= '0;
      r_prem      <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_div_zero  <= 1'b0;
      r_ovf       <= 1'b0;
      r_quot      <= '0;
      r_rem       <= '0;
`ifdef BOOTH_SDIV_EARLY_EXIT_EN
      r_early     <= 1'b0;
`endif
    end else begin
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_sign_q   <= dividend[DW_N-1] ^ divisor[DW_D-1];
            r_sign_r   <= dividend[DW_N-1];
            r_dz       <= ~|divisor;
            r_ovf_c    <= w_ovf_c;
            r_dmag     <= w_dmag;
            r_in_ready <= 1'b0;
`ifdef BOOTH_SDIV_EARLY_EXIT_EN
            if (w_skip) begin
              r_nmag  <= '0;
              r_prem  <= (DW_D+1)'(w_nmag);
              r_early <= 1'b1;
              r_state <= StFix;
            end else begin
`else
            begin
`endif
              r_nmag  <= w_nmag;
              r_prem  <= '0;
              r_cnt   <= CntW'(DW_N - 1);
              r_state <= StCalc;
            end
          end
        end
        StCalc: begin
          r_nmag <= {r_nmag[DW_N-2:0], w_ge};
          r_prem <= w_ge ? w_sub : w_shift[DW_D:0];
          r_cnt  <= r_cnt - CntW'(1);
          if (r_cnt == '0) r_state <= StFix;
        end
        StFix: begin
`ifdef BOOTH_SDIV_EARLY_EXIT_EN
          // Bypassed operations spend one extra FIX cycle to keep a fixed two-cycle latency.
          if (r_early) begin
            r_early <= 1'b0;
          end else begin
`else
          begin
`endif
            if (r_dz) begin
              r_quot <= '1;
              r_rem  <= '0;
            end else begin
              r_quot <= r_sign_q ? -r_nmag : r_nmag;
              r_rem  <= r_sign_r ? -w_rmag : w_rmag;
            end
            r_div_zero  <= r_dz;
            r_ovf       <= r_ovf_c;
            r_out_valid <= 1'b1;
            r_state     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign quotient  = r_quot;
  assign remainder = r_rem;
  assign div_zero  = r_div_zero;
  assign ovf       = r_ovf;
endmodule

// File: tb/tb_booth_sdiv.sv
// tb_booth_sdiv: directed vectors for booth_sdiv; a scoreboard queue is filled at acceptance
// and drained by an independent monitor at each output handshake.
module tb_booth_sdiv;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_zero;
  logic        ovf;

  booth_sdiv #(.DW_N(16), .DW_D(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    logic        ov;
    int          lat;
    int          tacc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

`ifdef BOOTH_SDIV_EARLY_EXIT_EN
  localparam int LatShort = 2;
`else
  localparam int LatShort = 17;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  initial forever @(posedge clk) cyc++;

  // Monitor: measures output latency and drains the scoreboard on each handshake.
  initial begin
    int   t_valid;
    logic prev_ov;
    exp_t e;
    t_valid = 0;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid && !prev_ov) t_valid = cyc;
      prev_ov = out_valid;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          timeout("unexpected_result");
        end else begin
          e = exp_q.pop_front();
          chk("quotient", 32'(quotient), 32'(e.q));
          chk("remainder", 32'(remainder), 32'(e.r));
          chk("div_zero", 32'(div_zero), 32'(e.dz));
          chk("ovf", 32'(ovf), 32'(e.ov));
          if (e.lat > 0) chk("latency", 32'(t_valid - e.tacc), 32'(e.lat));
        end
      end
    end
  end

  task automatic issue(input logic [15:0] n, input logic [7:0] d, input logic [15:0] eq,
                       input logic [7:0] er, input logic edz, input logic eov, input int lat,
                       output int tacc);
    exp_t e;
    int   waited;
    dividend = n;
    divisor  = d;
    in_valid = 1'b1;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      timeout("accept");
      in_valid = 1'b0;
      tacc = -1;
      return;
    end
    tacc   = cyc + 1;
    e.q    = eq;
    e.r    = er;
    e.dz   = edz;
    e.ov   = eov;
    e.lat  = lat;
    e.tacc = tacc;
    exp_q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    while ((exp_q.size() != 0 || !in_ready) && waited < 200) begin
      @(posedge clk);
      #1 waited++;
    end
    if (exp_q.size() != 0 || !in_ready) timeout("drain");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, t3;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_div_zero", 32'(div_zero), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic quadrants and boundaries.
    issue(16'd100, 8'd7, 16'd14, 8'd2, 1'b0, 1'b0, 17, t0);
    issue(-16'sd100, 8'd7, -16'sd14, -8'sd2, 1'b0, 1'b0, 17, t0);
    issue(16'd100, -8'sd7, -16'sd14, 8'd2, 1'b0, 1'b0, 17, t0);
    issue(-16'sd100, -8'sd7, 16'd14, -8'sd2, 1'b0, 1'b0, 17, t0);
    issue(16'h8000, 8'hFF, 16'h8000, 8'd0, 1'b0, 1'b1, 17, t0);
    issue(16'h8000, 8'd1, 16'h8000, 8'd0, 1'b0, 1'b0, 17, t0);
    issue(16'd5, 8'd0, 16'hFFFF, 8'd0, 1'b1, 1'b0, LatShort, t0);
    issue(16'd3, 8'd100, 16'd0, 8'd3, 1'b0, 1'b0, LatShort, t0);
    wait_idle();

    // Backpressure: result must hold and a second request must not be taken.
    out_ready = 1'b0;
    issue(16'd100, 8'd7, 16'd14, 8'd2, 1'b0, 1'b0, 17, t0);
    for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
    if (!out_valid) timeout("bp_valid");
    dividend = 16'd9;
    divisor  = 8'd3;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_quotient", 32'(quotient), 32'd14);
      chk("bp_remainder", 32'(remainder), 32'd2);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    chk("bp_second_not_taken", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of iteration.
    issue(16'd1000, 8'd3, 16'd333, 8'd1, 1'b0, 1'b0, 17, t0);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_quotient", 32'(quotient), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    issue(16'd50, 8'd5, 16'd10, 8'd0, 1'b0, 1'b0, 17, t0);
    wait_idle();

    // Back-to-back issue with out_ready held high.
    issue(16'd1234, -8'sd56, -16'sd22, 8'd2, 1'b0, 1'b0, 17, t0);
    issue(-16'sd30000, 8'd127, -16'sd236, -8'sd28, 1'b0, 1'b0, 17, t1);
    chk("interval_1", 32'(t1 - t0), 32'd19);
    issue(16'd32767, -8'sd128, -16'sd255, 8'd127, 1'b0, 1'b0, 17, t2);
    chk("interval_2", 32'(t2 - t1), 32'd19);
    issue(-16'sd7, -8'sd2, 16'd3, -8'sd1, 1'b0, 1'b0, 17, t3);
    chk("interval_3", 32'(t3 - t2), 32'd19);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
